// File: rtl/sha256_miner_pkg.sv
// Shared widths, result record and byte-swap helper for the SHA-256 miner slice.
package sha256_miner_pkg;

  localparam int unsigned NONCE_W       = 32;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned HASH_W        = 256;
  localparam int unsigned TAG_DEPTH_DEF = 128;
  localparam int unsigned RES_DEPTH_DEF = 4;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [WORD_W-1:0]  msw;
  } result_t;

  // Reverse the four bytes of a 32-bit word (hash words to mining byte order).
  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_result_checker_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with async active-low reset and
// synchronous clear. A pop in the same cycle frees the slot for a push when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Status, accept decisions, pointer update and FWFT read data.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o && !clear_i;
    do_push  = push_i && (!full_o || do_pop) && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only visible through a non-empty read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sha256_result_checker.sv
// Tags issued nonces, matches them with in-order pipeline hashes, compares each
// hash against the difficulty target and queues winners on a ready/valid port.
module sha256_result_checker
  import sha256_miner_pkg::*;
#(
  parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF,
  parameter int unsigned RES_DEPTH = RES_DEPTH_DEF,
  parameter int unsigned CNT_W     = 48
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clear_i,
  input  logic             issue_valid_i,
  input  logic [31:0]      issue_nonce_i,
  input  logic             hash_valid_i,
  input  logic [31:0]      hash_0_i,
  input  logic [31:0]      hash_1_i,
  input  logic [31:0]      hash_2_i,
  input  logic [31:0]      hash_3_i,
  input  logic [31:0]      hash_4_i,
  input  logic [31:0]      hash_5_i,
  input  logic [31:0]      hash_6_i,
  input  logic [31:0]      hash_7_i,
  input  logic [255:0]     target_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_nonce_o,
  output logic [31:0]      res_msw_o,
  output logic [CNT_W-1:0] hash_count_o,
  output logic [15:0]      drop_count_o,
  output logic             tag_ovf_o,
  output logic             tag_unf_o
);

  logic [NONCE_W-1:0] tag_dout;
  logic               tag_full, tag_empty;
  result_t            res_din, res_dout;
  logic               res_full, res_empty;
  logic [HASH_W-1:0]  v;

  logic               c_hit_q, c_hit_d;
  logic [NONCE_W-1:0] c_nonce_q, c_nonce_d;
  logic [WORD_W-1:0]  c_msw_q, c_msw_d;
  logic [CNT_W-1:0]   hash_count_q, hash_count_d;
  logic [15:0]        drop_count_q, drop_count_d;
  logic               tag_ovf_q, tag_ovf_d;
  logic               tag_unf_q, tag_unf_d;

  sync_fifo #(.WIDTH(NONCE_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .clear_i (clear_i),
    .push_i  (issue_valid_i),
    .pop_i   (hash_valid_i),
    .din_i   (issue_nonce_i),
    .dout_o  (tag_dout),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  sync_fifo #(.WIDTH($bits(result_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .clear_i (clear_i),
    .push_i  (c_hit_q),
    .pop_i   (res_ready_i),
    .din_i   (res_din),
    .dout_o  (res_dout),
    .full_o  (res_full),
    .empty_o (res_empty)
  );

  // Stage C compare, sticky flags and statistics counters.
  always_comb begin
    v = {bswap32(hash_7_i), bswap32(hash_6_i), bswap32(hash_5_i), bswap32(hash_4_i),
         bswap32(hash_3_i), bswap32(hash_2_i), bswap32(hash_1_i), bswap32(hash_0_i)};
    c_hit_d      = 1'b0;
    c_nonce_d    = c_nonce_q;
    c_msw_d      = c_msw_q;
    hash_count_d = hash_count_q;
    drop_count_d = drop_count_q;
    tag_ovf_d    = tag_ovf_q;
    tag_unf_d    = tag_unf_q;
    if (clear_i) begin
      c_nonce_d    = '0;
      c_msw_d      = '0;
      hash_count_d = '0;
      drop_count_d = '0;
      tag_ovf_d    = 1'b0;
      tag_unf_d    = 1'b0;
    end else begin
      if (hash_valid_i) begin
        // An untagged hash is still counted but can never produce a result.
        c_hit_d      = !tag_empty && (v <= target_i);
        c_nonce_d    = tag_dout;
        c_msw_d      = bswap32(hash_7_i);
        hash_count_d = hash_count_q + 1'b1;
        if (tag_empty) tag_unf_d = 1'b1;
      end
      // Full with no pop in the same cycle means the push is refused.
      if (issue_valid_i && tag_full && !hash_valid_i) tag_ovf_d = 1'b1;
      if (c_hit_q && res_full && !res_ready_i && (drop_count_q != '1))
        drop_count_d = drop_count_q + 1'b1;
    end
  end

  // Stage C and statistics registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      c_hit_q      <= 1'b0;
      c_nonce_q    <= '0;
      c_msw_q      <= '0;
      hash_count_q <= '0;
      drop_count_q <= '0;
      tag_ovf_q    <= 1'b0;
      tag_unf_q    <= 1'b0;
    end else begin
      c_hit_q      <= c_hit_d;
      c_nonce_q    <= c_nonce_d;
      c_msw_q      <= c_msw_d;
      hash_count_q <= hash_count_d;
      drop_count_q <= drop_count_d;
      tag_ovf_q    <= tag_ovf_d;
      tag_unf_q    <= tag_unf_d;
    end
  end

  // Result packing and output mapping.
  always_comb begin
    res_din.nonce = c_nonce_q;
    res_din.msw   = c_msw_q;
    res_valid_o   = !res_empty;
    res_nonce_o   = res_dout.nonce;
    res_msw_o     = res_dout.msw;
    hash_count_o  = hash_count_q;
    drop_count_o  = drop_count_q;
    tag_ovf_o     = tag_ovf_q;
    tag_unf_o     = tag_unf_q;
  end

endmodule

// File: tb/tb_sha256_result_checker.sv
// Directed bench for sha256_result_checker: latency, target boundary, ordering,
// result back-pressure, tag FIFO flags, clear priority and async reset.
module tb_sha256_result_checker;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         clear_i;
  logic         issue_valid_i;
  logic [31:0]  issue_nonce_i;
  logic         hash_valid_i;
  logic [31:0]  h [8];
  logic [255:0] target_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic [31:0]  res_nonce_o;
  logic [31:0]  res_msw_o;
  logic [47:0]  hash_count_o;
  logic [15:0]  drop_count_o;
  logic         tag_ovf_o;
  logic         tag_unf_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] TGT_EASY = {32'h0000_0000, 32'hFFFF_0000, 192'h0};
  localparam logic [255:0] TGT_EQ   = {32'h1234_5678, 224'h0};
  localparam logic [255:0] TGT_EQM1 = {32'h1234_5677, {224{1'b1}}};

  always #5 clk = ~clk;

  sha256_result_checker #(.TAG_DEPTH(128), .RES_DEPTH(4), .CNT_W(48)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .clear_i      (clear_i),
    .issue_valid_i(issue_valid_i),
    .issue_nonce_i(issue_nonce_i),
    .hash_valid_i (hash_valid_i),
    .hash_0_i     (h[0]),
    .hash_1_i     (h[1]),
    .hash_2_i     (h[2]),
    .hash_3_i     (h[3]),
    .hash_4_i     (h[4]),
    .hash_5_i     (h[5]),
    .hash_6_i     (h[6]),
    .hash_7_i     (h[7]),
    .target_i     (target_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_nonce_o  (res_nonce_o),
    .res_msw_o    (res_msw_o),
    .hash_count_o (hash_count_o),
    .drop_count_o (drop_count_o),
    .tag_ovf_o    (tag_ovf_o),
    .tag_unf_o    (tag_unf_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hash(input logic [31:0] w7, input logic [31:0] rest);
    for (int i = 0; i < 7; i++) h[i] = rest;
    h[7] = w7;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; clear_i = 1'b0; issue_valid_i = 1'b0; issue_nonce_i = '0;
    hash_valid_i = 1'b0; res_ready_i = 1'b0; target_i = TGT_EASY;
    set_hash('0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(res_valid_o), 64'd0);
    chk("rst_nonce", 64'(res_nonce_o), 64'd0);
    chk("rst_msw",   64'(res_msw_o),   64'd0);
    chk("rst_hcnt",  64'(hash_count_o), 64'd0);
    chk("rst_drop",  64'(drop_count_o), 64'd0);
    chk("rst_flags", 64'({tag_ovf_o, tag_unf_o}), 64'd0);
    arst_n = 1'b1;
    tick();

    // Single hit with 65-cycle pipeline delay and 2-cycle result latency.
    issue_valid_i = 1'b1; issue_nonce_i = 32'h0000_0005;
    tick();
    issue_valid_i = 1'b0;
    repeat (64) tick();
    hash_valid_i = 1'b1; set_hash('0, '0);
    tick();
    hash_valid_i = 1'b0;
    chk("t1_valid_n1", 64'(res_valid_o), 64'd0);
    chk("t1_hcnt", 64'(hash_count_o), 64'd1);
    tick();
    chk("t1_valid_n2", 64'(res_valid_o), 64'd1);
    chk("t1_nonce", 64'(res_nonce_o), 64'h5);
    chk("t1_msw", 64'(res_msw_o), 64'h0);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("t1_popped", 64'(res_valid_o), 64'd0);

    // Target equality boundary: V == target hits, V > target misses.
    do_clear();
    issue_valid_i = 1'b1; issue_nonce_i = 32'hA; tick();
    issue_nonce_i = 32'hB; tick();
    issue_valid_i = 1'b0;
    target_i = TGT_EQ;
    hash_valid_i = 1'b1; set_hash(32'h7856_3412, '0);
    tick();
    target_i = TGT_EQM1;
    tick();
    hash_valid_i = 1'b0;
    chk("t2_valid", 64'(res_valid_o), 64'd1);
    chk("t2_nonce", 64'(res_nonce_o), 64'hA);
    chk("t2_msw", 64'(res_msw_o), 64'h1234_5678);
    chk("t2_hcnt", 64'(hash_count_o), 64'd2);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    tick();
    chk("t2_nohit", 64'(res_valid_o), 64'd0);

    // 70 overlapped issues/hashes; only indices 3 and 68 hit.
    target_i = TGT_EASY;
    do_clear();
    for (int c = 0; c < 135; c++) begin
      issue_valid_i = (c < 70);
      issue_nonce_i = 32'h100 + 32'(c);
      if (c >= 65) begin
        hash_valid_i = 1'b1;
        if (c - 65 == 3 || c - 65 == 68) set_hash('0, '0);
        else set_hash('1, '1);
      end else begin
        hash_valid_i = 1'b0;
      end
      tick();
    end
    issue_valid_i = 1'b0; hash_valid_i = 1'b0;
    tick();
    tick();
    chk("t3_hcnt", 64'(hash_count_o), 64'd70);
    chk("t3_valid", 64'(res_valid_o), 64'd1);
    chk("t3_first", 64'(res_nonce_o), 64'h103);
    res_ready_i = 1'b1;
    tick();
    chk("t3_second", 64'(res_nonce_o), 64'h144);
    tick();
    res_ready_i = 1'b0;
    chk("t3_empty", 64'(res_valid_o), 64'd0);
    chk("t3_flags", 64'({tag_ovf_o, tag_unf_o}), 64'd0);

    // Result back-pressure: 6 hits into a 4-deep FIFO.
    do_clear();
    for (int k = 0; k < 6; k++) begin
      issue_valid_i = 1'b1; issue_nonce_i = 32'h200 + 32'(k); tick();
    end
    issue_valid_i = 1'b0;
    hash_valid_i = 1'b1; set_hash('0, '0);
    repeat (6) tick();
    hash_valid_i = 1'b0;
    tick();
    tick();
    chk("t4_drop", 64'(drop_count_o), 64'd2);
    chk("t4_valid", 64'(res_valid_o), 64'd1);
    chk("t4_head", 64'(res_nonce_o), 64'h200);
    repeat (3) tick();
    chk("t4_hold_valid", 64'(res_valid_o), 64'd1);
    chk("t4_hold_nonce", 64'(res_nonce_o), 64'h200);
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain", 64'(res_nonce_o), 64'(32'h200 + 32'(k)));
      res_ready_i = 1'b1;
      tick();
    end
    res_ready_i = 1'b0;
    chk("t4_empty", 64'(res_valid_o), 64'd0);
    chk("t4_drop_final", 64'(drop_count_o), 64'd2);

    // Tag underflow, then fill to 128 and overflow.
    do_clear();
    hash_valid_i = 1'b1; set_hash('0, '0);
    tick();
    hash_valid_i = 1'b0;
    chk("t5_unf", 64'(tag_unf_o), 64'd1);
    chk("t5_unf_hcnt", 64'(hash_count_o), 64'd1);
    tick();
    tick();
    chk("t5_unf_nores", 64'(res_valid_o), 64'd0);
    set_hash('1, '1);
    for (int k = 0; k < 128; k++) begin
      issue_valid_i = 1'b1; issue_nonce_i = 32'h1000 + 32'(k); tick();
    end
    chk("t5_full_noovf", 64'(tag_ovf_o), 64'd0);
    hash_valid_i = 1'b1;
    tick();
    hash_valid_i = 1'b0;
    chk("t5_full_pushpop", 64'(tag_ovf_o), 64'd0);
    tick();
    issue_valid_i = 1'b0;
    chk("t5_ovf", 64'(tag_ovf_o), 64'd1);

    // clear_i beats a simultaneous issue and hash with a result pending.
    do_clear();
    set_hash('0, '0);
    issue_valid_i = 1'b1; issue_nonce_i = 32'h300; tick();
    issue_valid_i = 1'b0;
    hash_valid_i = 1'b1; tick();
    tick();
    hash_valid_i = 1'b0;
    issue_valid_i = 1'b1; issue_nonce_i = 32'h301; tick();
    issue_valid_i = 1'b0;
    chk("t6_pending", 64'(res_valid_o), 64'd1);
    chk("t6_pre_unf", 64'(tag_unf_o), 64'd1);
    clear_i = 1'b1; issue_valid_i = 1'b1; issue_nonce_i = 32'h302; hash_valid_i = 1'b1;
    tick();
    clear_i = 1'b0; issue_valid_i = 1'b0; hash_valid_i = 1'b0;
    chk("t6_clr_valid", 64'(res_valid_o), 64'd0);
    chk("t6_clr_hcnt", 64'(hash_count_o), 64'd0);
    chk("t6_clr_drop", 64'(drop_count_o), 64'd0);
    chk("t6_clr_flags", 64'({tag_ovf_o, tag_unf_o}), 64'd0);
    tick();
    tick();
    chk("t6_clr_nores", 64'(res_valid_o), 64'd0);
    hash_valid_i = 1'b1; tick();
    hash_valid_i = 1'b0;
    chk("t6_tag_flushed", 64'(tag_unf_o), 64'd1);

    // Asynchronous reset mid-stream.
    do_clear();
    issue_valid_i = 1'b1; issue_nonce_i = 32'h400; tick();
    issue_valid_i = 1'b1; issue_nonce_i = 32'h401;
    hash_valid_i = 1'b1; tick();
    issue_valid_i = 1'b0; hash_valid_i = 1'b0;
    tick();
    chk("t7_pending", 64'(res_valid_o), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(res_valid_o), 64'd0);
    chk("t7_rst_nonce", 64'(res_nonce_o), 64'd0);
    chk("t7_rst_hcnt", 64'(hash_count_o), 64'd0);
    chk("t7_rst_flags", 64'({tag_ovf_o, tag_unf_o}), 64'd0);
    tick();
    arst_n = 1'b1;
    tick();
    hash_valid_i = 1'b1; tick();
    hash_valid_i = 1'b0;
    chk("t7_tag_lost", 64'(tag_unf_o), 64'd1);
    tick();
    tick();
    chk("t7_nores", 64'(res_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
